// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter for VGA scan-out: display reads take phase 0 of every 4-pixel group,
// and the single pixel-writer port gets every other RAM cycle through a req/ack handshake.
module vga_fb_arbiter #(
    parameter int          H_START = 144,
    parameter int          V_START = 35,
    parameter int          H_DISP  = 640,
    parameter int          V_DISP  = 480,
    parameter int          FB_W    = 160,
    parameter int          FB_H    = 120,
    parameter logic [11:0] BG      = 12'h000
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    input  logic        disp_en,
    output logic [11:0] pixel_data,
    input  logic        wr_req,
    input  logic [14:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_ack,
    output logic        fb_en,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [11:0] fb_wdata,
    input  logic [11:0] fb_rdata,
    output logic        vblank,
    output logic        frame_start
);

    localparam logic [9:0]  H_OFF    = 10'(H_START - 4);
    localparam logic [9:0]  V_FIRST  = 10'(V_START);
    localparam logic [9:0]  V_END    = 10'(V_START + V_DISP);
    localparam logic [9:0]  H_SPAN   = 10'(H_DISP);
    localparam logic [14:0] FB_WORDS = 15'(FB_W * FB_H);

    logic [9:0]  hoff;
    logic [9:0]  vrel;
    logic [9:0]  row;
    logic [1:0]  phase;
    logic [7:0]  col;
    logic        line_active;
    logic        in_window;
    logic        rd_slot;
    logic        wr_in_range;
    logic [14:0] rd_addr;
    logic        grp_en;
    logic [11:0] nxt_px;

    // The fetch runs 4 clocks ahead of the screen, so the window is offset by one group.
    assign hoff        = hcnt - H_OFF;
    assign phase       = hoff[1:0];
    assign col         = hoff[9:2];
    assign vrel        = vcnt - V_FIRST;
    assign row         = vrel >> 2;
    assign line_active = (vcnt >= V_FIRST) && (vcnt < V_END);
    assign in_window   = line_active && (hoff < H_SPAN);
    assign rd_slot     = in_window && (phase == 2'd0) && disp_en;
    assign wr_in_range = wr_addr < FB_WORDS;
    assign rd_addr     = ({5'd0, row} << 7) + ({5'd0, row} << 5) + {7'd0, col};

    assign vblank      = !line_active;
    assign frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);

    // Out-of-range writer addresses are acked but never reach the RAM.
    always_comb begin
        wr_ack   = 1'b0;
        fb_en    = 1'b0;
        fb_we    = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
        if (rd_slot) begin
            fb_en   = 1'b1;
            fb_addr = rd_addr;
        end else if (wr_req) begin
            wr_ack   = 1'b1;
            fb_en    = wr_in_range;
            fb_we    = wr_in_range;
            fb_addr  = wr_addr;
            fb_wdata = wr_data;
        end
    end

    // grp_en freezes disp_en for a whole group so toggles never split a group.
    always_ff @(posedge vga_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            grp_en     <= 1'b0;
            nxt_px     <= '0;
            pixel_data <= '0;
        end else begin
            if (in_window && (phase == 2'd0))
                grp_en <= disp_en;
            if (in_window && (phase == 2'd1) && grp_en)
                nxt_px <= fb_rdata;
            if (phase == 2'd3) begin
                if (!in_window)
                    pixel_data <= '0;
                else if (grp_en)
                    pixel_data <= nxt_px;
                else
                    pixel_data <= BG;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: drives raw counters, models the framebuffer RAM,
// and scores pixel_data plus the RAM port decisions every cycle.
module tb_vga_fb_arbiter;

    localparam logic [11:0] BG_C = 12'hF00;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        disp_en;
    logic [11:0] pixel_data;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        fb_en;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_wdata;
    logic [11:0] fb_rdata = 12'h000;
    logic        vblank;
    logic        frame_start;

    always #20 vga_clk = ~vga_clk;

    vga_fb_arbiter #(.BG(BG_C)) dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .disp_en    (disp_en),
        .pixel_data (pixel_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .fb_en      (fb_en),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_rdata   (fb_rdata),
        .vblank     (vblank),
        .frame_start(frame_start)
    );

    // Single-port synchronous RAM, 1-cycle read latency.
    logic [11:0] ram [0:19199];
    always @(posedge vga_clk) begin
        if (fb_en && (fb_addr < 15'd19200)) begin
            if (fb_we)
                ram[fb_addr] <= fb_wdata;
            else
                fb_rdata <= ram[fb_addr];
        end
    end

    logic [11:0] ref_mem [0:19199];
    logic [11:0] exp_q[$];
    bit          grp_ref [0:159];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          h = 0;
    int          v = 0;
    int          skip_px = 0;
    bit          stream_wr = 1'b0;
    int          acks_win = 0;
    int          acks_all = 0;
    int          reads_win = 0;
    int          s_h;
    int          s_v;
    logic [11:0] s_px;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, s_h, s_v);
        end
    endtask

    function automatic logic [11:0] exp_px(input int hh, input int vv);
        int c;
        int r;
        if (vv >= 35 && vv < 515 && hh >= 144 && hh < 784) begin
            c = (hh - 144) / 4;
            r = (vv - 35) / 4;
            return grp_ref[c] ? ref_mem[r * 160 + c] : BG_C;
        end
        return 12'h000;
    endfunction

    task automatic jump(input int nh, input int nv);
        h = nh;
        v = nv;
        skip_px = 8;
    endtask

    // One clock cycle at the current (h, v) with the currently driven inputs.
    task automatic step();
        bit          active;
        bit          rd;
        bit          xfer;
        bit          inr;
        logic [14:0] rd_a;
        hcnt = h[9:0];
        vcnt = v[9:0];
        s_h  = h;
        s_v  = v;
        active = (v >= 35 && v < 515);
        if (active && h >= 140 && h < 780 && ((h - 140) % 4) == 0)
            grp_ref[(h - 140) / 4] = disp_en;
        if (sys_rst_n)
            exp_q.push_back(12'h000);
        else if (skip_px > 0)
            skip_px--;
        else
            exp_q.push_back(exp_px(h, v));
        rd   = active && disp_en && h >= 140 && h <= 776 && ((h - 140) % 4) == 0;
        rd_a = 15'(((v - 35) / 4) * 160 + (h - 140) / 4);
        inr  = wr_addr < 15'd19200;

        @(negedge vga_clk);
        s_px = pixel_data;
        if (exp_q.size() > 0)
            chk("pixel_data", 32'(pixel_data), 32'(exp_q.pop_front()));
        chk("vblank", 32'(vblank), 32'(!active));
        chk("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
        if (rd) begin
            chk("read_slot", 32'({wr_ack, fb_en, fb_we, fb_addr}), 32'({1'b0, 1'b1, 1'b0, rd_a}));
            if (h >= 140 && h < 780) reads_win++;
        end else if (wr_req) begin
            chk("write_slot", 32'({wr_ack, fb_en, fb_we, fb_addr}), 32'({1'b1, inr, inr, wr_addr}));
            chk("write_data", 32'(fb_wdata), 32'(wr_data));
        end else begin
            chk("idle_slot", 32'({wr_ack, fb_en, fb_we, fb_addr, fb_wdata}), 32'(0));
        end
        xfer = !rd && wr_req;
        if (xfer) begin
            acks_all++;
            if (h >= 140 && h < 780) acks_win++;
            if (inr) ref_mem[wr_addr] = wr_data;
        end

        @(posedge vga_clk);
        #1;
        if (xfer && stream_wr) begin
            wr_addr = wr_addr + 15'd1;
            wr_data = 12'($urandom_range(0, 4095));
        end
        h++;
        if (h == 800) begin
            h = 0;
            v++;
            if (v == 525) v = 0;
        end
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < 19200; i++) begin
            ram[i]     <= 12'(i % 4096);
            ref_mem[i]  = 12'(i % 4096);
        end
        sys_rst_n = 1'b1;
        disp_en   = 1'b0;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        hcnt      = '0;
        vcnt      = '0;

        // Reset state at the frame origin.
        for (int i = 0; i < 4; i++) step();
        sys_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Preloaded image on the first active lines.
        jump(0, 35);
        disp_en = 1'b1;
        for (int i = 0; i < 5 * 800; i++) begin
            step();
            if (s_v == 35 && s_h == 144) chk("tp_first_px", 32'(s_px), 32'h000);
            if (s_v == 35 && s_h == 148) chk("tp_second_px", 32'(s_px), 32'h001);
            if (s_v == 39 && s_h == 144) chk("tp_row1_px", 32'(s_px), 32'h0A0);
        end

        // Continuous writer on an active line (display reads row 100).
        jump(0, 435);
        acks_win  = 0;
        reads_win = 0;
        stream_wr = 1'b1;
        wr_addr   = 15'd0;
        wr_data   = 12'($urandom_range(0, 4095));
        wr_req    = 1'b1;
        for (int i = 0; i < 800; i++) step();
        wr_req    = 1'b0;
        stream_wr = 1'b0;
        chk("acks_in_window", 32'(acks_win), 32'd480);
        chk("reads_in_window", 32'(reads_win), 32'd160);

        // Out-of-range writes are acked and dropped; the last in-range word is written.
        jump(0, 10);
        wr_req  = 1'b1;
        wr_addr = 15'd19200;
        wr_data = 12'h123;
        step();
        wr_addr = 15'd32767;
        wr_data = 12'h456;
        step();
        wr_addr = 15'd19199;
        wr_data = 12'h5A5;
        step();
        wr_req = 1'b0;
        step();
        chk("ram_19199", 32'(ram[19199]), 32'h5A5);

        // Display disabled: BG in the active region, writer never blocked.
        jump(0, 300);
        disp_en   = 1'b0;
        acks_all  = 0;
        stream_wr = 1'b1;
        wr_addr   = 15'd1000;
        wr_req    = 1'b1;
        for (int i = 0; i < 800; i++) begin
            step();
            if (s_h == 400) chk("bg_mid_line", 32'(s_px), 32'(BG_C));
        end
        wr_req    = 1'b0;
        stream_wr = 1'b0;
        chk("acks_disp_off", 32'(acks_all), 32'd800);

        // disp_en drops at hcnt=201: the group already started keeps its colour.
        jump(0, 200);
        disp_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (h == 201) disp_en = 1'b0;
            step();
            if (s_h == 207) chk("toggle_last_colour", 32'(s_px), 32'h9AF);
            if (s_h == 208) chk("toggle_first_bg", 32'(s_px), 32'(BG_C));
        end

        // Reset pulse mid-line.
        jump(0, 100);
        disp_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (h == 300) sys_rst_n = 1'b1;
            if (h == 303) begin
                sys_rst_n = 1'b0;
                skip_px   = 5;
            end
            step();
            if (s_h == 300) chk("reset_async_clear", 32'(s_px), 32'h000);
            if (s_h == 308) chk("reset_resume", 32'(s_px), 32'hA29);
        end

        // Last active line and the first blank line after it.
        jump(0, 514);
        for (int i = 0; i < 1600; i++) begin
            step();
            if (s_v == 514 && s_h == 780) chk("last_group", 32'(s_px), 32'(ref_mem[19199]));
            if (s_v == 514 && s_h == 784) chk("line_end_zero", 32'(s_px), 32'h000);
        end

        // Frame wrap through (0,0).
        jump(795, 524);
        for (int i = 0; i < 12; i++) step();

        diffs = 0;
        for (int i = 0; i < 19200; i++)
            if (ram[i] !== ref_mem[i]) diffs++;
        chk("ram_contents", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares a single-port synchronous framebuffer RAM (160x120, 12-bit RGB) between VGA scan-out and one pixel-writer port (drawing engine/CPU). Sits between the VGA timing driver and `vga_out`'s pixel source, and replaces the fixed-colour display block. It takes the driver's raw `cnt_h`/`cnt_v`, prefetches one framebuffer word per 4 screen pixels at 4x4 upscale, and presents registered `pixel_data`. All remaining RAM cycles go to the writer through a req/ack handshake.

## Interface
- `H_START`, default 144: first active `cnt_h` (sync + back porch).
- `V_START`, default 35: first active `cnt_v`.
- `H_DISP`, default 640: active pixels per line.
- `V_DISP`, default 480: active lines.
- `FB_W`, default 160: framebuffer width in words, equal to `H_DISP/4`.
- `FB_H`, default 120: framebuffer height, equal to `V_DISP/4`.
- `BG`, default 12'h000: colour output while display is disabled.

Ports:
- `vga_clk`  in  1: clock (25 MHz pixel clock).
- `sys_rst_n`  in  1: reset, asynchronous, active-high.
- `hcnt`  in  10: driver horizontal counter, 0..799.
- `vcnt`  in  10: driver vertical counter, 0..524.
- `disp_en`  in  1: 1 = scan-out from framebuffer; 0 = output `BG` and give all slots to the writer.
- `pixel_data`  out  12: registered colour for the current `hcnt`/`vcnt`.
- `wr_req`  in  1: writer request, held until acked.
- `wr_addr`  in  15: writer word address, row*160+col.
- `wr_data`  in  12: writer colour.
- `wr_ack`  out  1: combinational grant; the write completes at this clock edge.
- `fb_en`  out  1: RAM enable.
- `fb_we`  out  1: RAM write enable.
- `fb_addr`  out  15: RAM address.
- `fb_wdata`  out  12: RAM write data.
- `fb_rdata`  in  12: RAM read data, valid 1 cycle after the read edge.
- `vblank`  out  1: high while `vcnt` is outside [V_START, V_START+V_DISP).
- `frame_start`  out  1: one-cycle pulse at `hcnt`==0 and `vcnt`==0.

## Operation
- Fetch window:
  - `hoff` = `hcnt` − (H_START−4), computed mod 1024.
  - The line is fetching when `hoff` < H_DISP, `vcnt` is in the active range, and `disp_en`=1.
  - `phase` = `hoff[1:0]`; `col` = `hoff[9:2]` (0..159); `row` = (`vcnt`−V_START)>>2 (0..119).
- Slot schedule on a fetching line:
  - `phase`=0 is a display read: `fb_en`=1, `fb_we`=0, `fb_addr` = row*160 + col, computed as (row<<7)+(row<<5)+col, 15 bits.
  - `phase`=1..3 are writer slots.
- Writer slot rule:
  - If `wr_req`=1, then `wr_ack`=1 and `fb_en` = `fb_we` = (`wr_addr` < 19200), with `fb_addr`=`wr_addr` and `fb_wdata`=`wr_data`.
  - An out-of-range address (≥19200) is acked and dropped; no RAM write occurs.
- All cycles outside fetch windows are writer slots, including blanking, inactive lines and `disp_en`=0.
- Display read always has priority. `wr_ack`=0 in `phase`=0 slots, and the request waits.
- Idle, no writer request: `fb_en`=0, `fb_we`=0, `fb_addr`=0, `fb_wdata`=0.
- Datapath registers:
  - `nxt_px` captures `fb_rdata` on the edge ending `phase`=1 of a fetching cycle group.
  - `pixel_data` loads on the edge ending `phase`=3:
    - `nxt_px` if that group's 4 pixels fall in the active region and `disp_en`=1;
    - `BG` if in the active region with `disp_en`=0;
    - 12'h000 otherwise.
  - Result: `pixel_data` holds colour (row,col) for `hcnt` in [H_START+4col, H_START+4col+3] on every active line. Each word repeats on 4 lines.
- `disp_en` is sampled per group at `phase`=0. Toggling it mid-line takes effect at the next group boundary, with no partial groups.
- `frame_start` and `vblank` are combinational decodes of `hcnt`/`vcnt`.

## Timing
- Reset (asynchronous): `pixel_data`=0 and `nxt_px`=0. Combinational outputs follow the inputs immediately.
- Read latency:
  - Display read is issued at `hcnt`=H_START+4c−4.
  - Data is captured at H_START+4c−3.
  - It is visible on `pixel_data` from `hcnt`=H_START+4c.
- First read of a line is at `hcnt`=H_START−4 (140). Last read is at H_START+H_DISP−8 (776).
- `pixel_data` returns to 0 from `hcnt`=H_START+H_DISP (784).
- Writer bandwidth:
  - Active lines: 3 of 4 slots from 140..779; all other cycles free.
  - Worst-case `wr_ack` wait is 1 cycle.
- Handshake rules:
  - A transfer occurs on the edge where `wr_req` and `wr_ack` are both 1.
  - The writer may change `wr_addr`/`wr_data` only after an ack.
  - Dropping `wr_req` without an ack is allowed.
- Wrap-around:
  - `hoff` wraps for `hcnt` < 140, so no fetch occurs.
  - `vcnt`=524→0 starts a new frame; `row` decoding restarts at `vcnt`=35.
- Reset mid-line: registers clear immediately. Output resumes correctly from the next group boundary after release, because state derives from `hcnt`/`vcnt`.

## Test plan
- Preload RAM with word = address mod 4096, `disp_en`=1, run one frame → at `hcnt`=144..147 on `vcnt`=35..38, `pixel_data`=0x000; at `hcnt`=148, `pixel_data`=0x001; at `vcnt`=39, `hcnt`=144, `pixel_data`=0x0A0 (160).
- `wr_req` held continuously with incrementing addresses from 0 through one active line → no ack on `phase`-0 cycles; exactly 480 acks in `hcnt` 140..779 and 160 display reads; RAM contents match.
- Write at `wr_addr`=19200 and at 32767 → `wr_ack`=1, `fb_we`=0, RAM unchanged; next request at 19199 is written.
- `disp_en`=0 with `BG`=0xF00 → `pixel_data`=0xF00 across the active region, 0 in blanking, `wr_ack` never blocked.
- Toggle `disp_en` 1→0 at `hcnt`=201 → groups change exactly at the next 4-pixel boundary, with no partial group.
- Assert reset at `hcnt`=300, `vcnt`=100 for 3 cycles → `pixel_data`=0 immediately; correct framebuffer colours resume from the first full group after release; `frame_start` pulses at (0,0).
